// File: rtl/uart_ctrl_burst.sv
// Byte-stream command controller between the UART byte layer and the external-I/O RAMs.
// Frames: CMD, ADDR (MSB first), LEN (words-1), then payload for WRITE. Supports burst
// write/read with address auto-increment, write ACK byte, status readback, soft-reset/run
// pulses and an optional inter-byte timeout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_data, rx_valid         received byte + one-cycle strobe
//   tx_data, tx_valid, tx_ready  transmit byte with valid/ready handshake
//   ext_wr_addr/data/en       RAM write port (one-cycle strobe)
//   ext_rd_addr, ext_rd_data  RAM read port, data valid RD_LAT cycles after address
//   swrst, run                one-cycle command pulses
//   busy                      high whenever not idle
//   err_timeout               one-cycle pulse on a timeout abort
module uart_ctrl_burst #(
  parameter int unsigned DIN_W       = 128,
  parameter int unsigned DOUT_W      = 128,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] ext_wr_addr,
  output logic [DIN_W-1:0]  ext_wr_data,
  output logic              ext_wr_en,
  output logic [ADDR_W-1:0] ext_rd_addr,
  input  logic [DOUT_W-1:0] ext_rd_data,
  output logic              swrst,
  output logic              run,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned RX_BYTES   = (DIN_W + 7) / 8;
  localparam int unsigned TX_BYTES   = (DOUT_W + 7) / 8;
  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned MAX_BYTES  = (RX_BYTES > TX_BYTES) ?
                                       ((RX_BYTES > ADDR_BYTES) ? RX_BYTES : ADDR_BYTES) :
                                       ((TX_BYTES > ADDR_BYTES) ? TX_BYTES : ADDR_BYTES);
  localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned LAT_W      = $clog2(RD_LAT + 1);
  localparam int unsigned GAP_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StAddr, StLen, StWrData, StWrAck, StRdWait, StRdData, StStat
  } state_e;

  state_e                    state_q, state_d;
  logic                      is_write_q, is_write_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]                word_cnt_q, word_cnt_d;
  logic [RX_BYTES*8-1:0]     wr_buf_q, wr_buf_d;
  logic [TX_BYTES*8-1:0]     rd_buf_q, rd_buf_d;
  logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [3:0]                timeout_cnt_q, timeout_cnt_d;
  logic [3:0]                badcmd_cnt_q, badcmd_cnt_d;
  logic [ADDR_W-1:0]         ext_wr_addr_q, ext_wr_addr_d;
  logic [DIN_W-1:0]          ext_wr_data_q, ext_wr_data_d;
  logic                      ext_wr_en_q, ext_wr_en_d;
  logic                      swrst_q, swrst_d;
  logic                      run_q, run_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      timeout_hit;

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    byte_cnt_d    = byte_cnt_q;
    word_cnt_d    = word_cnt_q;
    wr_buf_d      = wr_buf_q;
    rd_buf_d      = rd_buf_q;
    lat_cnt_d     = lat_cnt_q;
    gap_d         = '0;
    timeout_cnt_d = timeout_cnt_q;
    badcmd_cnt_d  = badcmd_cnt_q;
    ext_wr_addr_d = ext_wr_addr_q;
    ext_wr_data_d = ext_wr_data_q;
    ext_wr_en_d   = 1'b0;
    swrst_d       = 1'b0;
    run_d         = 1'b0;
    err_timeout_d = 1'b0;
    timeout_hit   = 1'b0;

    // Gap counter only runs while a frame is being received; a byte arriving in the
    // expiry cycle wins over the timeout.
    if (TIMEOUT_CYC != 0 &&
        (state_q == StAddr || state_q == StLen || state_q == StWrData) && !rx_valid) begin
      if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
      else                                  gap_d = gap_q + 1'b1;
    end

    if (timeout_hit) begin
      // Partial word is discarded; completed words stay written.
      state_d       = StIdle;
      byte_cnt_d    = '0;
      err_timeout_d = 1'b1;
      if (timeout_cnt_q != 4'hF) timeout_cnt_d = timeout_cnt_q + 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            byte_cnt_d = '0;
            case (rx_data)
              8'h10: begin is_write_d = 1'b1; state_d = StAddr; end
              8'h20: begin is_write_d = 1'b0; state_d = StAddr; end
              8'h30: swrst_d = 1'b1;
              8'h40: run_d = 1'b1;
              8'h50: state_d = StStat;
              default: if (badcmd_cnt_q != 4'hF) badcmd_cnt_d = badcmd_cnt_q + 1'b1;
            endcase
          end
        end
        StAddr: begin
          if (rx_valid) begin
            addr_d = ADDR_W'({addr_q, rx_data});
            if (byte_cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = StLen;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        StLen: begin
          if (rx_valid) begin
            word_cnt_d = rx_data;
            lat_cnt_d  = '0;
            state_d    = is_write_q ? StWrData : StRdWait;
          end
        end
        StWrData: begin
          if (rx_valid) begin
            for (int unsigned i = 0; i < RX_BYTES; i++) begin
              if (byte_cnt_q == CNT_W'(i)) wr_buf_d[i*8 +: 8] = rx_data;
            end
            if (byte_cnt_q == CNT_W'(RX_BYTES - 1)) begin
              ext_wr_en_d   = 1'b1;
              ext_wr_addr_d = addr_q;
              ext_wr_data_d = wr_buf_d[DIN_W-1:0];
              addr_d        = addr_q + 1'b1;
              byte_cnt_d    = '0;
              if (word_cnt_q == 8'd0) state_d = StWrAck;
              else                    word_cnt_d = word_cnt_q - 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        StWrAck: begin
          if (tx_ready) state_d = StIdle;
        end
        StRdWait: begin
          if (lat_cnt_q == LAT_W'(RD_LAT)) begin
            rd_buf_d               = '0;
            rd_buf_d[DOUT_W-1:0]   = ext_rd_data;
            byte_cnt_d             = '0;
            state_d                = StRdData;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        StRdData: begin
          if (tx_ready) begin
            if (byte_cnt_q == CNT_W'(TX_BYTES - 1)) begin
              byte_cnt_d = '0;
              if (word_cnt_q == 8'd0) begin
                state_d = StIdle;
              end else begin
                word_cnt_d = word_cnt_q - 1'b1;
                addr_d     = addr_q + 1'b1;
                lat_cnt_d  = '0;
                state_d    = StRdWait;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              rd_buf_d   = rd_buf_q << 8;
            end
          end
        end
        StStat: begin
          if (tx_ready) begin
            timeout_cnt_d = '0;
            badcmd_cnt_d  = '0;
            state_d       = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      wr_buf_q      <= '0;
      rd_buf_q      <= '0;
      lat_cnt_q     <= '0;
      gap_q         <= '0;
      timeout_cnt_q <= '0;
      badcmd_cnt_q  <= '0;
      ext_wr_addr_q <= '0;
      ext_wr_data_q <= '0;
      ext_wr_en_q   <= 1'b0;
      swrst_q       <= 1'b0;
      run_q         <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      byte_cnt_q    <= byte_cnt_d;
      word_cnt_q    <= word_cnt_d;
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      lat_cnt_q     <= lat_cnt_d;
      gap_q         <= gap_d;
      timeout_cnt_q <= timeout_cnt_d;
      badcmd_cnt_q  <= badcmd_cnt_d;
      ext_wr_addr_q <= ext_wr_addr_d;
      ext_wr_data_q <= ext_wr_data_d;
      ext_wr_en_q   <= ext_wr_en_d;
      swrst_q       <= swrst_d;
      run_q         <= run_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Reply byte is decoded from registered state only, so it is stable until the handshake.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      StWrAck:  begin tx_valid = 1'b1; tx_data = ACK_BYTE; end
      StRdData: begin tx_valid = 1'b1; tx_data = rd_buf_q[TX_BYTES*8-1 -: 8]; end
      StStat:   begin tx_valid = 1'b1; tx_data = {timeout_cnt_q, badcmd_cnt_q}; end
      default:  ;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign ext_rd_addr = addr_q;
  assign ext_wr_addr = ext_wr_addr_q;
  assign ext_wr_data = ext_wr_data_q;
  assign ext_wr_en   = ext_wr_en_q;
  assign swrst       = swrst_q;
  assign run         = run_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_ctrl_burst.sv
// Self-checking bench for uart_ctrl_burst (DIN_W=32, DOUT_W=24, RD_LAT=3, TIMEOUT_CYC=100).
module tb_uart_ctrl_burst;
  localparam int unsigned DIN_W       = 32;
  localparam int unsigned DOUT_W      = 24;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned RD_LAT      = 3;
  localparam int unsigned TIMEOUT_CYC = 100;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] ext_wr_addr;
  logic [DIN_W-1:0]  ext_wr_data;
  logic              ext_wr_en;
  logic [ADDR_W-1:0] ext_rd_addr;
  logic [DOUT_W-1:0] ext_rd_data;
  logic              swrst;
  logic              run;
  logic              busy;
  logic              err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  uart_ctrl_burst #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .TIMEOUT_CYC(TIMEOUT_CYC), .ACK_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data), .ext_wr_en(ext_wr_en),
    .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
    .swrst(swrst), .run(run), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: RD_LAT-deep register pipeline behind the read address.
  logic [23:0] ram [256];
  logic [23:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= ram[ext_rd_addr];
    p2 <= p1;
    p3 <= p2;
  end
  assign ext_rd_data = p3;

  logic [61:0] outs;
  assign outs = {tx_valid, tx_data, ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr,
                 swrst, run, busy, err_timeout};

  logic [7:0]  wr_a_q[$];
  logic [31:0] wr_d_q[$];
  int          to_pulses = 0;
  always @(negedge clk) begin
    if (ext_wr_en) begin
      wr_a_q.push_back(ext_wr_addr);
      wr_d_q.push_back(ext_wr_data);
    end
    if (err_timeout) to_pulses++;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic recv_byte(input int stall, output logic [7:0] b, output bit ok);
    int waited;
    bit stable;
    waited = 0;
    stable = 1'b1;
    ok     = 1'b0;
    b      = '0;
    while (tx_valid !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (tx_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_wait: tx_valid=%b after %0d cycles, required 1", tx_valid, waited);
      return;
    end
    b = tx_data;
    repeat (stall) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== b) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_errors++;
      $display("FAIL tx_hold: valid=%b data=%h, required 1/%h held", tx_valid, tx_data, b);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    bit ok;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_outs: got %h, required 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h50);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_status: got %h, required 00", b);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] frame [11] = '{8'h10, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] b;
    bit ok;
    wr_a_q.delete(); wr_d_q.delete();
    foreach (frame[i]) send_byte(frame[i]);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'hA5) begin
      n_errors++;
      $display("FAIL wr_ack: got %h, required a5", b);
    end
    n_checks++;
    if (wr_a_q.size() != 2) begin
      n_errors++;
      $display("FAIL wr_count: got %0d, required 2", wr_a_q.size());
    end else begin
      n_checks++;
      if (wr_a_q[0] !== 8'h05 || wr_d_q[0] !== 32'h44332211) begin
        n_errors++;
        $display("FAIL wr_word0: got %h/%h, required 05/44332211", wr_a_q[0], wr_d_q[0]);
      end
      n_checks++;
      if (wr_a_q[1] !== 8'h06 || wr_d_q[1] !== 32'h88776655) begin
        n_errors++;
        $display("FAIL wr_word1: got %h/%h, required 06/88776655", wr_a_q[1], wr_d_q[1]);
      end
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] exp [6] = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
    logic [7:0] b;
    bit ok;
    ram[8'hFF] = 24'hABCDEF;
    ram[8'h00] = 24'h123456;
    send_byte(8'h20); send_byte(8'hFF); send_byte(8'h01);
    foreach (exp[i]) begin
      recv_byte(5, b, ok);
      n_checks++;
      if (b !== exp[i]) begin
        n_errors++;
        $display("FAIL rd_wrap_byte%0d: got %h, required %h", i, b, exp[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_wrap_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_control();
    logic [7:0] cmds [2] = '{8'h30, 8'h40};
    logic [7:0] b;
    bit ok;
    foreach (cmds[i]) begin
      rx_data = cmds[i]; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      n_checks++;
      if ({swrst, run} !== ((i == 0) ? 2'b10 : 2'b01) || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL ctrl_pulse%0d: swrst=%b run=%b busy=%b", i, swrst, run, busy);
      end
      @(negedge clk);
      n_checks++;
      if ({swrst, run} !== 2'b00) begin
        n_errors++;
        $display("FAIL ctrl_width%0d: swrst=%b run=%b, required 0/0", i, swrst, run);
      end
    end
    send_byte(8'h7E);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL badcmd_idle: busy=%b, required 0", busy);
    end
    send_byte(8'h50);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'h01) begin
      n_errors++;
      $display("FAIL status_badcmd: got %h, required 01", b);
    end
    send_byte(8'h50);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'h00) begin
      n_errors++;
      $display("FAIL status_cleared: got %h, required 00", b);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] frame [5] = '{8'h10, 8'h00, 8'h00, 8'h11, 8'h22};
    logic [7:0] b;
    bit ok;
    int n_wr0, to0, k;
    n_wr0 = wr_a_q.size();
    to0   = to_pulses;
    foreach (frame[i]) send_byte(frame[i]);
    // Now in the first idle cycle after the last byte; abort expected after 100 idle cycles.
    k = 0;
    while (err_timeout !== 1'b1 && k < 130) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 100) begin
      n_errors++;
      $display("FAIL timeout_delay: pulse seen at idle cycle %0d, required 100", k);
    end
    @(negedge clk);
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b0 || to_pulses - to0 != 1) begin
      n_errors++;
      $display("FAIL timeout_pulse: err=%b busy=%b pulses=%0d, required 0/0/1",
               err_timeout, busy, to_pulses - to0);
    end
    n_checks++;
    if (wr_a_q.size() != n_wr0) begin
      n_errors++;
      $display("FAIL timeout_nowrite: writes=%0d, required %0d", wr_a_q.size(), n_wr0);
    end
    send_byte(8'h50);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'h10) begin
      n_errors++;
      $display("FAIL timeout_status: got %h, required 10", b);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    bit          ok;
    logic [7:0]  base;
    int          len, op;
    logic [7:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] w;
    logic [23:0] rw;
    logic [7:0]  e;
    for (int it = 0; it < 12; it++) begin
      op   = $urandom_range(0, 2);
      base = 8'($urandom);
      len  = $urandom_range(0, 3);
      if (op == 0) begin
        wr_a_q.delete(); wr_d_q.delete(); exp_a.delete(); exp_d.delete();
        send_byte(8'h10); send_byte(base); send_byte(8'(len));
        for (int wi = 0; wi <= len; wi++) begin
          w = '0;
          for (int j = 0; j < 4; j++) begin
            b = 8'($urandom);
            w = w | (32'(b) << (8 * j));
            send_byte(b);
            repeat ($urandom_range(0, 15)) @(negedge clk);
          end
          exp_a.push_back(8'((int'(base) + wi) % 256));
          exp_d.push_back(w);
        end
        recv_byte($urandom_range(0, 3), b, ok);
        n_checks++;
        if (b !== 8'hA5 || wr_a_q.size() != exp_a.size()) begin
          n_errors++;
          $display("FAIL rnd_wr%0d: ack=%h writes=%0d, required a5/%0d",
                   it, b, wr_a_q.size(), exp_a.size());
        end else begin
          foreach (exp_a[i]) begin
            n_checks++;
            if (wr_a_q[i] !== exp_a[i] || wr_d_q[i] !== exp_d[i]) begin
              n_errors++;
              $display("FAIL rnd_wr%0d_w%0d: got %h/%h, required %h/%h",
                       it, i, wr_a_q[i], wr_d_q[i], exp_a[i], exp_d[i]);
            end
          end
        end
      end else if (op == 1) begin
        send_byte(8'h20); send_byte(base); send_byte(8'(len));
        for (int wi = 0; wi <= len; wi++) begin
          rw = ram[(int'(base) + wi) % 256];
          for (int j = 0; j < 3; j++) begin
            e = 8'(rw >> (8 * (2 - j)));
            recv_byte($urandom_range(0, 3), b, ok);
            n_checks++;
            if (b !== e) begin
              n_errors++;
              $display("FAIL rnd_rd%0d_w%0d_b%0d: got %h, required %h", it, wi, j, b, e);
            end
          end
        end
      end else begin
        send_byte(8'h50);
        recv_byte($urandom_range(0, 3), b, ok);
        n_checks++;
        if (b !== 8'h00) begin
          n_errors++;
          $display("FAIL rnd_status%0d: got %h, required 00", it, b);
        end
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] frame [7] = '{8'h10, 8'h40, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] b;
    bit ok;
    int waited;
    send_byte(8'h20); send_byte(8'h10); send_byte(8'h00);
    waited = 0;
    while (tx_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (tx_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midrd_wait: tx_valid=%b, required 1", tx_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL midrd_reset_outs: got %h, required 0", outs);
    end
    rst = 1'b0;
    wr_a_q.delete(); wr_d_q.delete();
    foreach (frame[i]) send_byte(frame[i]);
    recv_byte(0, b, ok);
    n_checks++;
    if (b !== 8'hA5 || wr_a_q.size() != 1) begin
      n_errors++;
      $display("FAIL midrd_write: ack=%h writes=%0d, required a5/1", b, wr_a_q.size());
    end else begin
      n_checks++;
      if (wr_a_q[0] !== 8'h40 || wr_d_q[0] !== 32'hEFBEADDE) begin
        n_errors++;
        $display("FAIL midrd_word: got %h/%h, required 40/efbeadde", wr_a_q[0], wr_d_q[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 24'($urandom);
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_control();
    test_timeout();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
